// File: rtl/counter_ctrl.sv
// Command-side controller for the interval counter: start/stop/clear/configure over valid/ready,
// auto-halt with a one-cycle done pulse when the readback count hits a programmed target.
module counter_ctrl #(
    parameter int          CLEAR_CYCLES     = 2,
    parameter logic [31:0] DEFAULT_INTERVAL = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cnt_value,
    output logic [7:0]  state,
    output logic [31:0] interval,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_CLR} fsm_t;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_SET_INT = 3'd1;
    localparam logic [2:0] OP_SET_TGT = 3'd2;
    localparam logic [2:0] OP_START   = 3'd3;
    localparam logic [2:0] OP_STOP    = 3'd4;
    localparam logic [2:0] OP_CLEAR   = 3'd5;

    localparam logic [3:0] CLR_LOAD = 4'(CLEAR_CYCLES - 1);

    fsm_t        fsm, fsm_nxt;
    logic [3:0]  clr_cnt, clr_cnt_nxt;
    logic [31:0] target, target_nxt;
    logic [31:0] interval_nxt;
    logic [7:0]  state_nxt;
    logic        done_nxt, err_nxt;
    logic        accept, match;

    assign accept = cmd_valid && cmd_ready;
    assign match  = (fsm == S_RUN) && (target != 32'd0) && (cnt_value == target);

    always_comb begin
        fsm_nxt      = fsm;
        clr_cnt_nxt  = clr_cnt;
        target_nxt   = target;
        interval_nxt = interval;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        case (fsm)
            S_IDLE, S_HALT: begin
                if (accept) begin
                    case (cmd_op)
                        OP_NOP:     ;
                        OP_SET_INT: interval_nxt = cmd_data;
                        OP_SET_TGT: target_nxt   = cmd_data;
                        OP_START:   fsm_nxt      = S_RUN;
                        OP_STOP:    err_nxt      = (fsm == S_IDLE);
                        OP_CLEAR: begin
                            fsm_nxt     = S_CLR;
                            clr_cnt_nxt = CLR_LOAD;
                        end
                        default:    err_nxt      = 1'b1;
                    endcase
                end
            end
            S_RUN: begin
                // CLEAR beats a same-cycle target match and suppresses done
                if (accept && cmd_op == OP_CLEAR) begin
                    fsm_nxt     = S_CLR;
                    clr_cnt_nxt = CLR_LOAD;
                end else if (match) begin
                    fsm_nxt  = S_HALT;
                    done_nxt = 1'b1;
                end else if (accept && cmd_op == OP_STOP) begin
                    fsm_nxt = S_HALT;
                end
                if (accept && (cmd_op == OP_SET_INT || cmd_op == OP_SET_TGT || cmd_op >= 3'd6))
                    err_nxt = 1'b1;
            end
            S_CLR: begin
                if (clr_cnt == 4'd0)
                    fsm_nxt = S_IDLE;
                else
                    clr_cnt_nxt = clr_cnt - 4'd1;
            end
            default: fsm_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        state_nxt = 8'd0;
        if (fsm_nxt == S_RUN)
            state_nxt = 8'd1;
        else if (fsm_nxt == S_HALT)
            state_nxt = 8'd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_IDLE;
            clr_cnt   <= 4'd0;
            target    <= 32'd0;
            interval  <= DEFAULT_INTERVAL;
            state     <= 8'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            fsm       <= fsm_nxt;
            clr_cnt   <= clr_cnt_nxt;
            target    <= target_nxt;
            interval  <= interval_nxt;
            state     <= state_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            busy      <= (fsm_nxt == S_RUN);
            cmd_ready <= (fsm_nxt != S_CLR);
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed-vector bench for counter_ctrl with hand-computed expectations.
module tb_counter_ctrl;

    localparam logic [31:0] DEF_INT = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_data;
    logic [31:0] cnt_value;
    logic [7:0]  state;
    logic [31:0] interval;
    logic        done, err, busy;

    int n_checks = 0;
    int n_pass   = 0;

    counter_ctrl #(.CLEAR_CYCLES(2), .DEFAULT_INTERVAL(DEF_INT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cnt_value (cnt_value),
        .state     (state),
        .interval  (interval),
        .done      (done),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge; caller guarantees cmd_ready is high.
    task automatic cmd(input logic [2:0] op, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = 32'd0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("wait_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int n;
        logic [31:0] seq [6];

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 32'd0; cnt_value = 32'd0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_state", {24'd0, state}, 32'd0);
        chk("rst_interval", interval, DEF_INT);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_flags", {29'd0, done, err, busy}, 32'd0);

        // configure and run to target 5
        cmd(3'd1, 32'd3);
        chk("set_interval", interval, 32'd3);
        cmd(3'd2, 32'd5);
        cmd(3'd3, 32'd0);
        chk("start_state", {24'd0, state}, 32'd1);
        chk("start_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cnt_value = i;
            tick();
            chk("run_pre_target", {23'd0, state, done}, {23'd0, 8'd1, 1'b0});
        end
        cnt_value = 32'd5;
        tick();
        chk("target_halt", {22'd0, state, done, busy}, {22'd0, 8'd2, 1'b1, 1'b0});
        tick();
        chk("done_one_cycle", {23'd0, state, done}, {23'd0, 8'd2, 1'b0});

        // resume, stop, resume, clear
        cnt_value = 32'd6;
        cmd(3'd3, 32'd0);
        chk("resume", {24'd0, state}, 32'd1);
        cmd(3'd4, 32'd0);
        chk("stop_run", {24'd0, state}, 32'd2);
        cmd(3'd3, 32'd0);
        chk("resume2", {24'd0, state}, 32'd1);
        cmd(3'd5, 32'd0);
        chk("clear_state", {23'd0, state, cmd_ready}, 32'd0);
        cmd_valid = 1'b1; cmd_op = 3'd3;
        n = 0;
        while (!cmd_ready && n < 20) begin
            chk("clr_window_state", {24'd0, state}, 32'd0);
            tick();
            n++;
        end
        chk("clr_cycles", n, 32'd2);
        chk("clr_held_not_taken", {24'd0, state}, 32'd0);
        tick();
        cmd_valid = 1'b0; cmd_op = 3'd0;
        chk("held_start_taken", {24'd0, state}, 32'd1);
        chk("interval_kept", interval, 32'd3);

        // illegal commands
        cmd(3'd1, 32'd9);
        chk("setint_run_err", {31'd0, err}, 32'd1);
        chk("setint_run_keep", interval, 32'd3);
        chk("setint_run_state", {24'd0, state}, 32'd1);
        tick();
        chk("err_one_cycle", {31'd0, err}, 32'd0);
        cmd(3'd5, 32'd0);
        wait_ready();
        cmd(3'd7, 32'd0);
        chk("rsvd_err", {23'd0, state, err}, {23'd0, 8'd0, 1'b1});
        cmd(3'd4, 32'd0);
        chk("stop_idle_err", {23'd0, state, err}, {23'd0, 8'd0, 1'b1});
        cmd(3'd0, 32'd0);
        chk("nop_quiet", {23'd0, state, err}, 32'd0);

        // simultaneous events: STOP, CLEAR, START each with a target match
        cmd(3'd2, 32'd4);
        cnt_value = 32'd0;
        cmd(3'd3, 32'd0);
        cnt_value = 32'd4;
        cmd(3'd4, 32'd0);
        chk("match_stop", {23'd0, state, done}, {23'd0, 8'd2, 1'b1});
        cnt_value = 32'd0;
        cmd(3'd3, 32'd0);
        cnt_value = 32'd4;
        cmd(3'd5, 32'd0);
        chk("match_clear", {22'd0, state, done, cmd_ready}, 32'd0);
        wait_ready();
        cnt_value = 32'd0;
        cmd(3'd3, 32'd0);
        cnt_value = 32'd4;
        cmd(3'd3, 32'd0);
        chk("match_start", {23'd0, state, done}, {23'd0, 8'd2, 1'b1});

        // target 0 disables auto-halt, including across wrap
        cmd(3'd2, 32'd0);
        cnt_value = 32'd0;
        cmd(3'd3, 32'd0);
        seq = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 6; i++) begin
            cnt_value = seq[i];
            tick();
            chk("tgt0_no_halt", {23'd0, state, done}, {23'd0, 8'd1, 1'b0});
        end
        cmd(3'd4, 32'd0);

        // target below current count halts only after the wrap
        cnt_value = 32'd10;
        cmd(3'd2, 32'd3);
        cmd(3'd3, 32'd0);
        seq = '{32'd11, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd2};
        for (int i = 0; i < 5; i++) begin
            cnt_value = seq[i];
            tick();
            chk("overshoot_run", {23'd0, state, done}, {23'd0, 8'd1, 1'b0});
        end
        cnt_value = 32'd3;
        tick();
        chk("wrap_halt", {23'd0, state, done}, {23'd0, 8'd2, 1'b1});

        // reset while running clears state and target
        cnt_value = 32'd0;
        cmd(3'd3, 32'd0);
        chk("pre_rst_run", {24'd0, state}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrun_rst", {21'd0, state, busy, cmd_ready, done}, {21'd0, 8'd0, 1'b0, 1'b1, 1'b0});
        chk("midrun_rst_interval", interval, DEF_INT);
        cmd(3'd3, 32'd0);
        cnt_value = 32'd3;
        tick();
        chk("rst_target_zero", {23'd0, state, done}, {23'd0, 8'd1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
